// File: rtl/fmap_writer.sv
// ---------------------------------------------------------------------------
// fmap_writer
//   Output-side feature-map collector. Accepts one convolution result per
//   clock (all K channels of one (row, col) location, raster order) and
//   stores it channel-major, so that element (k, row, col) sits at flat
//   address k*num*num + row*num + col. Once a whole num x num x K frame is
//   resident the block stops accepting and raises frame_done until the
//   consumer pulses release_i. The frame is read back through a registered
//   read port that stays live in both states.
//
// Ports
//   clk          single clock
//   reset        synchronous, active-low
//   in_valid     in_data holds a result
//   in_ready     block can take a result (depends on state only)
//   in_data      K channels, channel k at [k*DATA_WIDTH +: DATA_WIDTH]
//   release_i    consumer done with the frame; re-arm for the next one
//                ("release" itself is a reserved word in SystemVerilog)
//   rd_en        read request
//   rd_addr      flat address k*num*num + row*num + col
//   rd_data      registered read data, holds when rd_en is low
//   frame_done   full frame resident
//   overrun      sticky: a result was offered while the frame was full
// ---------------------------------------------------------------------------
module fmap_writer #(
    parameter int num        = 256,
    parameter int K          = 2,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_W     = 17
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [0:K*DATA_WIDTH-1] in_data,
    input  logic                    release_i,
    input  logic                    rd_en,
    input  logic [ADDR_W-1:0]       rd_addr,
    output logic [DATA_WIDTH-1:0]   rd_data,
    output logic                    frame_done,
    output logic                    overrun
);

    localparam int NN   = num * num;
    localparam int RC_W = (num > 1) ? $clog2(num) : 1;
    localparam int LA_W = (NN > 1) ? $clog2(NN) : 1;

    typedef enum logic {
        S_FILL = 1'b0,
        S_FULL = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [RC_W-1:0]        row_q, row_d;
    logic [RC_W-1:0]        col_q, col_d;
    logic                   overrun_q, overrun_d;
    logic [DATA_WIDTH-1:0]  rd_data_q;

    logic                   accept;
    logic                   wr_en;
    logic [LA_W-1:0]        wr_addr;

    logic [K-1:0]                 hit;
    logic [K-1:0][LA_W-1:0]       laddr;
    logic [K-1:0][DATA_WIDTH-1:0] bank_rd;
    logic [DATA_WIDTH-1:0]        rd_mux;

    // -----------------------------------------------------------------------
    // Control FSM and raster position
    // -----------------------------------------------------------------------
    assign in_ready   = (state_q == S_FILL);
    assign frame_done = (state_q == S_FULL);
    assign overrun    = overrun_q;
    assign accept     = in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        overrun_d = overrun_q;
        unique case (state_q)
            S_FILL: begin
                if (accept) begin
                    if (col_q == RC_W'(num - 1)) begin
                        col_d = '0;
                        if (row_q == RC_W'(num - 1)) begin
                            row_d   = '0;
                            state_d = S_FULL;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            S_FULL: begin
                if (in_valid) overrun_d = 1'b1;
                // release wins over a same-cycle offer: the new frame
                // starts with a clean overrun flag
                if (release_i) begin
                    state_d   = S_FILL;
                    overrun_d = 1'b0;
                end
            end
            default: state_d = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q   <= S_FILL;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
            rd_data_q <= '0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
            if (rd_en) rd_data_q <= rd_mux;
        end
    end

    // -----------------------------------------------------------------------
    // Storage: one bank per channel, each num*num deep. The flat address
    // space is the concatenation of the banks, channel 0 first.
    // -----------------------------------------------------------------------
    // No write on a reset edge: the position is being discarded anyway.
    assign wr_en   = accept && reset;
    assign wr_addr = LA_W'(row_q) * LA_W'(num) + LA_W'(col_q);

    for (genvar k = 0; k < K; k++) begin : g_ch
        localparam logic [ADDR_W:0] LO = (ADDR_W+1)'(k * NN);
        localparam logic [ADDR_W:0] HI = (ADDR_W+1)'((k + 1) * NN);

        assign hit[k]   = ({1'b0, rd_addr} >= LO) && ({1'b0, rd_addr} < HI);
        assign laddr[k] = LA_W'(rd_addr - LO[ADDR_W-1:0]);

        fmap_bank #(
            .DEPTH (NN),
            .AW    (LA_W),
            .DW    (DATA_WIDTH)
        ) u_bank (
            .clk     (clk),
            .we_i    (wr_en),
            .waddr_i (wr_addr),
            .wdata_i (in_data[k*DATA_WIDTH +: DATA_WIDTH]),
            .raddr_i (laddr[k]),
            .rdata_o (bank_rd[k])
        );
    end

    // Out-of-range addresses hit no bank and read as zero. The bank output
    // is the pre-edge array content, so a same-cycle write is not visible.
    always_comb begin
        rd_mux = '0;
        for (int k = 0; k < K; k++) begin
            if (hit[k]) rd_mux = bank_rd[k];
        end
    end

    assign rd_data = rd_data_q;

endmodule

// ---------------------------------------------------------------------------
// fmap_bank
//   One channel's plane of the frame: DEPTH words, synchronous write,
//   combinational read (the top registers the selected word). Contents are
//   not reset.
//
// Ports
//   clk      clock
//   we_i     write enable
//   waddr_i  write address (row*num + col)
//   wdata_i  write data
//   raddr_i  read address
//   rdata_o  read data, current array content
// ---------------------------------------------------------------------------
module fmap_bank #(
    parameter int DEPTH = 16,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: tb/tb_fmap_writer.sv
module tb_fmap_writer;

    localparam int NUM = 4;
    localparam int KCH = 2;
    localparam int DW  = 16;
    localparam int AW  = 6;
    localparam int NN  = NUM * NUM;
    localparam int TOT = KCH * NN;

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [0:KCH*DW-1] in_data;
    logic              release_i;
    logic              rd_en;
    logic [AW-1:0]     rd_addr;
    logic [DW-1:0]     rd_data;
    logic              frame_done;
    logic              overrun;

    always #5 clk = ~clk;

    fmap_writer #(.num(NUM), .K(KCH), .DATA_WIDTH(DW), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .release_i  (release_i),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .frame_done (frame_done),
        .overrun    (overrun)
    );

    // Reference model: the frame as a flat array, a count of accepted
    // locations in the current frame, and the full/overrun flags.
    logic [DW-1:0] model [0:TOT-1];
    bit            m_full;
    bit            m_ovr;
    int            m_pos;
    logic [DW-1:0] m_rd;
    int            total = 0;
    int            bad   = 0;

    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock: drive inputs, advance the model, check every output.
    task automatic step(input logic v, input logic [DW-1:0] c0, input logic [DW-1:0] c1,
                        input logic rel, input logic re, input logic [AW-1:0] a,
                        input logic rst_n);
        in_valid  = v;
        in_data   = {c0, c1};
        release_i = rel;
        rd_en     = re;
        rd_addr   = a;
        reset     = rst_n;
        if (!rst_n) begin
            m_full = 0; m_ovr = 0; m_pos = 0; m_rd = '0;
        end else begin
            if (re) m_rd = (int'(a) < TOT) ? model[a] : '0;
            if (!m_full) begin
                if (v) begin
                    model[m_pos]      = c0;
                    model[NN + m_pos] = c1;
                    m_pos++;
                    if (m_pos == NN) begin
                        m_pos  = 0;
                        m_full = 1;
                    end
                end
            end else begin
                if (v) m_ovr = 1;
                if (rel) begin
                    m_full = 0;
                    m_ovr  = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        chk("in_ready",   {15'b0, in_ready},   {15'b0, !m_full});
        chk("frame_done", {15'b0, frame_done}, {15'b0, m_full});
        chk("overrun",    {15'b0, overrun},    {15'b0, m_ovr});
        chk("rd_data",    rd_data,             m_rd);
    endtask

    // Offer n results. Pattern data is 16'h0{k}{row}{col} + off; otherwise
    // random. Optional random idle cycles and random reads alongside.
    task automatic stream(input int n, input bit gaps, input logic [DW-1:0] off,
                          input bit rnd, input bit reads);
        int            acc;
        int            iter;
        logic          v;
        logic          re;
        logic [AW-1:0] a;
        logic [DW-1:0] c0, c1, loc;
        acc  = 0;
        iter = 0;
        while (acc < n) begin
            iter++;
            if (iter > 1000) begin
                total++; bad++;
                $error("FAIL stream_bound got=%0d exp=%0d accepts", acc, n);
                break;
            end
            v   = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            loc = 16'(((m_pos / NUM) << 4) | (m_pos % NUM));
            c0  = rnd ? 16'($urandom) : loc + off;
            c1  = rnd ? 16'($urandom) : 16'h0100 + loc + off;
            re  = reads ? 1'($urandom_range(0, 1)) : 1'b0;
            a   = AW'($urandom_range(0, 63));
            step(v, c0, c1, 1'b0, re, a, 1'b1);
            if (v) acc++;
        end
    endtask

    task automatic readback();
        for (int a = 0; a < 64; a++) step(1'b0, '0, '0, 1'b0, 1'b1, AW'(a), 1'b1);
    endtask

    initial begin
        logic [DW-1:0] old5;
        logic [DW-1:0] d0;
        logic [DW-1:0] d1;

        // reset state
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b0, '0, 1'b0);

        // frame 1: back-to-back pattern, no reads while memory is unwritten
        stream(16, 1'b0, 16'h0000, 1'b0, 1'b0);
        step(1'b0, '0, '0, 1'b0, 1'b1, AW'(16 + 2*4 + 3), 1'b1);
        chk("rd_k1_r2_c3", rd_data, 16'h0123);
        readback();

        // offers while full are dropped and flag overrun
        for (int i = 0; i < 3; i++) step(1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b1);
        chk("addr0_kept", rd_data, 16'h0000);

        // release, then same pattern with random gaps must give same memory
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
        stream(16, 1'b1, 16'h0000, 1'b0, 1'b1);
        readback();

        // release, frame 2 with +0x1000
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
        stream(16, 1'b1, 16'h1000, 1'b0, 1'b1);
        readback();

        // reset after 7 accepts discards position
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
        stream(7, 1'b0, 16'h2000, 1'b0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, '0, 1'b0);
        d0 = 16'($urandom);
        d1 = 16'($urandom);
        step(1'b1, d0, d1, 1'b0, 1'b0, '0, 1'b1);
        step(1'b0, '0, '0, 1'b0, 1'b1, AW'(0), 1'b1);
        chk("post_rst_a0", rd_data, d0);
        step(1'b0, '0, '0, 1'b0, 1'b1, AW'(16), 1'b1);
        chk("post_rst_a16", rd_data, d1);
        stream(15, 1'b1, '0, 1'b1, 1'b1);
        readback();

        // same-cycle read and write to address 5
        step(1'b0, '0, '0, 1'b1, 1'b0, '0, 1'b1);
        stream(5, 1'b0, 16'h3000, 1'b0, 1'b0);
        old5 = model[5];
        step(1'b1, 16'hBEEF, 16'h1234, 1'b0, 1'b1, AW'(5), 1'b1);
        chk("rw_old", rd_data, old5);
        step(1'b0, '0, '0, 1'b0, 1'b1, AW'(5), 1'b1);
        chk("rw_new", rd_data, 16'hBEEF);

        // random soak: offers, releases (also in FILL), reads incl. out of range
        for (int i = 0; i < 400; i++) begin
            step(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
                 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                 AW'($urandom_range(0, 63)), 1'b1);
        end
        readback();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
